// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg: shared addresses, FSM encodings and status-word layout
package uart_tx_scheduler_pkg;
  localparam logic [31:0] UART_TX_ADDR     = 32'h1000_0000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_0004;
  typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, WAIT = 2'd2} state_e;
  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_LEVEL_W   = 8;
  localparam int STAT_EMPTY_BIT = STAT_LEVEL_LSB + STAT_LEVEL_W;
  localparam int STAT_FULL_BIT  = STAT_EMPTY_BIT + 1;
  localparam int STAT_BUSY_BIT  = STAT_FULL_BIT + 1;
  localparam int STAT_OVF_BIT   = STAT_BUSY_BIT + 1;
endpackage

// File: rtl/uart_tx_scheduler_fifo.sv
// sync_fifo: synchronous FIFO with extra-bit pointers, occupancy level and flush
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q, wptr_d, rptr_d;
  logic do_push, do_pop;
  // A flush discards the same-edge write and moves the read pointer onto the write pointer
  always_comb begin
    do_push = push_i && !full_o && !flush_i;
    do_pop  = pop_i && !empty_o && !flush_i;
    wptr_d  = wptr_q + (AW+1)'(do_push);
    rptr_d  = flush_i ? wptr_q : rptr_q + (AW+1)'(do_pop);
  end
  // Pointer registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  assign level_o = wptr_q - rptr_q;
  assign full_o  = level_o == (AW+1)'(DEPTH);
  assign empty_o = level_o == '0;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: paces buffered CPU bytes into one uart_wr strobe per frame; UART_TX_FLUSH_EN adds a flush input
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int BIT_CYCLES   = 868,
  parameter int FRAME_BITS   = 10,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef UART_TX_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   clr_ovf,
  output logic                   uart_wr,
  output logic [7:0]             uart_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   overflow
);
  localparam int FRAME_CYCLES = BIT_CYCLES * FRAME_BITS + GUARD_CYCLES;
  localparam int CW = $clog2(FRAME_CYCLES + 1);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0] dat_q, head;
  logic uart_wr_q, ovf_q, ovf_d, pop, flush_w;
`ifdef UART_TX_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif
  assign pop = state_q == IDLE && !empty && !flush_w;
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en),
    .pop_i   (pop),
    .flush_i (flush_w),
    .wdata_i (wr_data),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
  // A dropped write sets the flag and wins over a same-edge clear
  always_comb ovf_d = (wr_en && full && !flush_w) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
  // Overflow flag register
  always_ff @(posedge clk or negedge rst)
    if (!rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  // Frame sequencer: pop a byte, strobe once, then wait out the frame plus guard time
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dat_q     <= '0;
      uart_wr_q <= 1'b0;
    end else begin
      uart_wr_q <= 1'b0;
      case (state_q)
        IDLE: if (pop) begin
          dat_q   <= head;
          state_q <= STROBE;
        end
        STROBE: begin
          uart_wr_q <= 1'b1;
          cnt_q     <= CW'(FRAME_CYCLES - 1);
          state_q   <= WAIT;
        end
        WAIT: if (cnt_q == '0) state_q <= IDLE;
              else cnt_q <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  assign uart_wr  = uart_wr_q;
  assign uart_dat = dat_q;
  assign overflow = ovf_q;
  assign busy     = state_q != IDLE || !empty;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized and directed checks against a queue-based timing model
module tb_uart_tx_scheduler;
  localparam int DEPTH = 4;
  localparam int F = 4 * 10 + 2;
  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, clr_ovf = 1'b0, flush = 1'b0;
  logic [7:0] wr_data = '0;
  logic uart_wr, full, empty, busy, overflow;
  logic [7:0] uart_dat;
  logic [2:0] level;
  int checks = 0, errors = 0;

  uart_tx_scheduler #(.DEPTH(DEPTH), .BIT_CYCLES(4), .FRAME_BITS(10), .GUARD_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef UART_TX_FLUSH_EN
    .flush    (flush),
`endif
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .uart_wr  (uart_wr),
    .uart_dat (uart_dat),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus the rule that pops are at least F+2 edges apart
  logic [7:0] mq[$];
  logic [7:0] m_dat = '0;
  logic m_ovf = 1'b0;
  int t = 0, last_pop = -1000, next_pop = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_dat = '0;
      m_ovf = 1'b0;
      last_pop = -1000;
      next_pop = 0;
    end else begin
      automatic bit full_pre = mq.size() == DEPTH;
      automatic bit drop = wr_en && full_pre && !flush;
      t++;
      if (mq.size() > 0 && t >= next_pop && !flush) begin
        m_dat = mq.pop_front();
        last_pop = t;
        next_pop = t + F + 2;
      end
      if (flush) mq.delete();
      else if (wr_en && !full_pre) mq.push_back(wr_data);
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  // Monitor: compare every output against the model mid-cycle, log strobes
  int strobes = 0, ncyc = 0, max_lvl = 0;
  int st_t[$];
  logic [7:0] st_d[$];
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      automatic logic e_wr = (t == last_pop + 1);
      automatic logic e_busy = mq.size() > 0 || t <= last_pop + F;
      checks += 6;
      if (uart_wr !== e_wr) begin errors++; $display("FAIL mon_uart_wr t=%0d got %b exp %b", t, uart_wr, e_wr); end
      if (uart_dat !== m_dat) begin errors++; $display("FAIL mon_uart_dat t=%0d got %h exp %h", t, uart_dat, m_dat); end
      if (level !== 3'(mq.size())) begin errors++; $display("FAIL mon_level t=%0d got %0d exp %0d", t, level, mq.size()); end
      if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
        errors++; $display("FAIL mon_flags t=%0d got e%b f%b exp e%b f%b", t, empty, full, mq.size() == 0, mq.size() == DEPTH);
      end
      if (busy !== e_busy) begin errors++; $display("FAIL mon_busy t=%0d got %b exp %b", t, busy, e_busy); end
      if (overflow !== m_ovf) begin errors++; $display("FAIL mon_overflow t=%0d got %b exp %b", t, overflow, m_ovf); end
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (uart_wr === 1'b1) begin
        strobes++;
        st_t.push_back(ncyc);
        st_d.push_back(uart_dat);
      end
    end
  end

  task automatic drive(input logic we, input logic [7:0] d, input logic clr, input logic fl);
    wr_en = we; wr_data = d; clr_ovf = clr; flush = fl;
    @(posedge clk); #1;
    wr_en = 1'b0; clr_ovf = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int i;
    for (i = 0; i < bound && (busy || uart_wr); i++) @(negedge clk);
    ok = !(busy || uart_wr);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({uart_wr, uart_dat, full, empty, level, busy, overflow} !== {1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_values got wr%b dat%h f%b e%b l%0d b%b o%b", uart_wr, uart_dat, full, empty, level, busy, overflow);
    end
    rst = 1'b1;
    idle(10);
    checks++;
    if (strobes !== 0 || empty !== 1'b1 || level !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got strobes %0d e%b l%0d b%b exp 0 1 0 0", strobes, empty, level, busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (uart_wr !== 1'b1 || uart_dat !== 8'h41 || busy !== 1'b1) begin
      errors++; $display("FAIL single_latency got wr%b dat%h busy%b exp 1 41 1", uart_wr, uart_dat, busy);
    end
    wait_idle(100, ok);
    checks++;
    if (!ok || strobes !== 1) begin errors++; $display("FAIL single_done got ok%0d strobes %0d exp 1 1", ok, strobes); end
  endtask

  task automatic test_burst();
    int s0 = strobes;
    bit ok;
    max_lvl = 0;
    for (int i = 1; i <= 3; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    wait_idle(300, ok);
    checks++;
    if (!ok || strobes - s0 !== 3) begin errors++; $display("FAIL burst_count got %0d exp 3", strobes - s0); end
    else begin
      checks += 3;
      if (st_t[s0+1] - st_t[s0] !== 44 || st_t[s0+2] - st_t[s0+1] !== 44) begin
        errors++; $display("FAIL burst_spacing got %0d %0d exp 44 44", st_t[s0+1] - st_t[s0], st_t[s0+2] - st_t[s0+1]);
      end
      if ({st_d[s0], st_d[s0+1], st_d[s0+2]} !== 24'h010203) begin
        errors++; $display("FAIL burst_order got %h %h %h exp 01 02 03", st_d[s0], st_d[s0+1], st_d[s0+2]);
      end
      if (max_lvl !== 2) begin errors++; $display("FAIL burst_peak got %0d exp 2", max_lvl); end
    end
  endtask

  task automatic test_overflow();
    int s0 = strobes;
    bit ok;
    max_lvl = 0;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    checks += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    if (max_lvl !== 4) begin errors++; $display("FAIL ovf_peak got %0d exp 4", max_lvl); end
    wait_idle(400, ok);
    checks++;
    if (!ok || strobes - s0 !== 5 || st_d[s0+4] !== 8'h14) begin
      errors++; $display("FAIL ovf_sent got ok%0d count %0d exp 5", ok, strobes - s0);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask

  task automatic test_reset_mid();
    int s0;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    idle(10);
    checks++;
    if (level !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL mid_queued got level %0d busy %b exp 2 1", level, busy); end
    s0 = strobes;
    #3 rst = 1'b0;
    wr_en = 1'b1;
    #1;
    checks++;
    if ({uart_wr, uart_dat, full, empty, level, busy, overflow} !== {1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset got wr%b dat%h f%b e%b l%0d b%b o%b", uart_wr, uart_dat, full, empty, level, busy, overflow);
    end
    repeat (2) @(posedge clk);
    #1 wr_en = 1'b0;
    rst = 1'b1;
    idle(100);
    checks++;
    if (strobes !== s0 || empty !== 1'b1) begin errors++; $display("FAIL mid_after got strobes %0d empty %b exp %0d 1", strobes, empty, s0); end
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 15) < 2, 8'($urandom), $urandom_range(0, 31) == 0, 1'b0);
    wait_idle(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL random_drain got busy %b exp 0", busy); end
  endtask

`ifdef UART_TX_FLUSH_EN
  task automatic test_flush();
    int s0 = strobes;
    bit ok;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    idle(5);
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    checks++;
    if (empty !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL flush_empty got e%b b%b exp 1 1", empty, busy); end
    wait_idle(100, ok);
    idle(60);
    checks++;
    if (!ok || strobes - s0 !== 1 || empty !== 1'b1) begin
      errors++; $display("FAIL flush_strobes got ok%0d count %0d exp 1", ok, strobes - s0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_reset_mid();
    test_random();
`ifdef UART_TX_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sequences the free-running `uart` transmit core for the CPU. The core has no busy/ready output, so back-to-back CPU stores to UART_TX_ADDR would overrun it.
- Buffers store bytes in a FIFO and issues exactly one uart_wr pulse per byte, spaced by one full frame time.
- Sits between the store path (uart_we/uart_data) and the uart instance. Also exposes status for a memory-mapped status read.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- BIT_CYCLES, 868, clk cycles per UART bit (100 MHz / 115200).
- FRAME_BITS, 10, bits per frame (start + 8 data + stop).
- GUARD_CYCLES, 2, extra idle cycles added after each frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  CPU store to UART_TX_ADDR; one byte per cycle high
- wr_data  in  8  byte to transmit
- clr_ovf  in  1  clears the overflow flag
- uart_wr  out  1  one-cycle write strobe to the uart core
- uart_dat  out  8  byte to the uart core; stable while uart_wr is high and for the whole frame
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- busy  out  1  FSM not in IDLE, or FIFO not empty
- overflow  out  1  sticky; set when a write is dropped

Behaviour:
- Reset (rst low, async): FIFO pointers 0; all outputs 0 except empty=1; FSM = IDLE; frame counter = 0.
- FIFO:
  - Synchronous; push on a wr_en rising edge when not full.
  - Push while full: byte dropped, overflow set on that edge.
  - Push and pop on the same edge with the FIFO non-empty: both occur and level is unchanged.
  - Pointers wrap modulo DEPTH.
  - level = wptr - rptr, using pointers with one extra bit.
- FSM states:
  - IDLE: if !empty, pop the head into uart_dat and go to STROBE.
  - STROBE: uart_wr = 1 for exactly this cycle; load counter with FRAME_CYCLES-1; go to WAIT.
  - WAIT: decrement the counter each cycle; at 0 go to IDLE.
- FRAME_CYCLES = BIT_CYCLES*FRAME_BITS + GUARD_CYCLES. Counter width is $clog2(FRAME_CYCLES+1), arithmetic unsigned.
- Latency: a byte pushed into an empty FIFO while the FSM is in IDLE on edge N gives uart_wr high during the cycle after edge N+2.
- Strobe-to-strobe spacing between consecutive queued bytes: exactly FRAME_CYCLES+2 cycles.
- uart_dat is held until the next pop; it is never changed during WAIT.
- overflow: clr_ovf clears it. If clr_ovf and a dropping write occur on the same edge, set wins.
- Reset asserted mid-frame aborts immediately. uart_wr drops asynchronously and the queued bytes are lost. The uart core shares rst and resets too.
- wr_en is ignored while rst is low.

Optional Feature:
- Macro: UART_TX_FLUSH_EN.
- When defined:
  - Adds input `flush` (1 bit).
  - A flush edge empties the FIFO (rptr <= wptr) and discards any same-edge write.
  - The frame in progress (STROBE/WAIT) completes normally.
  - overflow is unaffected.
- When not defined: port absent; the FIFO is only drained by transmission.

Decomposition:
- Shared constants go in the shared define header:
  - UART_TX_ADDR and UART_STATUS_ADDR.
  - FSM state encodings (IDLE=2'd0, STROBE=2'd1, WAIT=2'd2).
  - Status-word bit positions: {overflow, busy, full, empty, level}.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH), provides push/pop/full/empty/level/overflow-free core logic.
- The scheduler adds the FSM, frame counter and overflow flag.

Test Plan (BIT_CYCLES=4, GUARD_CYCLES=2 → FRAME_CYCLES=42, DEPTH=4):
1. Reset release, idle 10 cycles → uart_wr never high, empty=1, level=0, busy=0.
2. Single write 0x41 on edge N → uart_wr high exactly one cycle after edge N+2, uart_dat=0x41, busy=1; busy falls after the WAIT count completes.
3. Burst of 3 writes 0x01, 0x02, 0x03 on consecutive cycles → three strobes spaced exactly 44 cycles apart, data in order, level peaks at 2.
4. 6 back-to-back writes with DEPTH=4 → overflow=1, level max 4. Exactly 5 bytes transmitted: one popped at edge N+1, then 4 buffered. Pulse clr_ovf → overflow=0.
5. Assert rst mid-WAIT with 2 bytes queued → outputs at reset values immediately; no further strobes after release.
6. (UART_TX_FLUSH_EN) queue 3 bytes, pulse flush during the first WAIT → first frame completes, no further strobes, empty=1.
